// File: rtl/nand_cycle_gen.sv
// nand_cycle_gen: timed NAND flash bus cycle generator (cmd/addr/write/read strobes).
// Optional NAND_RB_WAIT_EN gates acceptance on a synchronized F_nRB.
module nand_cycle_gen #(
    parameter int T_SU = 1,
    parameter int T_WP = 2,
    parameter int T_WH = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       REQ_VALID,
    input  logic [1:0] REQ_TYPE,
    input  logic [7:0] REQ_DATA,
    input  logic       REQ_LAST,
    output logic       REQ_READY,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       F_nCE,
    output logic       F_CLE,
    output logic       F_ALE,
    output logic       F_nWE,
    output logic       F_nRE,
    output logic [7:0] F_DIO_OUT,
    output logic       F_DIO_OE,
    input  logic [7:0] F_DIO_IN,
    input  logic       F_nRB
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [1:0] typ;
    logic       lst;
    logic       rb_ok;
`ifdef NAND_RB_WAIT_EN
    logic [1:0] rb_sync;
    always_ff @(posedge PCLK)
        rb_sync <= PRESET ? 2'b00 : {rb_sync[0], F_nRB};
    assign rb_ok = rb_sync[1];
`else
    logic unused_nrb;
    assign unused_nrb = F_nRB;
    assign rb_ok = 1'b1;
`endif
    assign REQ_READY = (state == IDLE) && !PRESET && rb_ok;
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            typ       <= 2'b00;
            lst       <= 1'b0;
            F_nCE     <= 1'b1;
            F_CLE     <= 1'b0;
            F_ALE     <= 1'b0;
            F_nWE     <= 1'b1;
            F_nRE     <= 1'b1;
            F_DIO_OE  <= 1'b0;
            F_DIO_OUT <= 8'h00;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= 8'h00;
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                IDLE: if (REQ_VALID && REQ_READY) begin
                    state     <= SETUP;
                    cnt       <= 4'(T_SU - 1);
                    typ       <= REQ_TYPE;
                    lst       <= REQ_LAST;
                    F_DIO_OUT <= REQ_DATA;
                    F_nCE     <= 1'b0;
                    F_CLE     <= REQ_TYPE == 2'b00;
                    F_ALE     <= REQ_TYPE == 2'b01;
                    F_DIO_OE  <= REQ_TYPE != 2'b11;
                end
                SETUP: if (cnt == 4'd0) begin
                    state <= PULSE;
                    cnt   <= 4'(T_WP - 1);
                    F_nWE <= typ == 2'b11;
                    F_nRE <= typ != 2'b11;
                end else cnt <= cnt - 4'd1;
                PULSE: if (cnt == 4'd0) begin
                    state <= HOLD;
                    cnt   <= 4'(T_WH - 1);
                    F_nWE <= 1'b1;
                    F_nRE <= 1'b1;
                    if (typ == 2'b11) begin
                        RSP_DATA  <= F_DIO_IN;
                        RSP_VALID <= 1'b1;
                    end
                end else cnt <= cnt - 4'd1;
                HOLD: if (cnt == 4'd0) begin
                    state    <= IDLE;
                    F_nCE    <= lst;
                    F_CLE    <= 1'b0;
                    F_ALE    <= 1'b0;
                    F_DIO_OE <= 1'b0;
                end else cnt <= cnt - 4'd1;
            endcase
        end
    end
endmodule
